// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter sequencer: parameter defaults,
// counter widths and the FSM state encoding.
package iir_pkg;

  localparam int IIR_N_DEFAULT    = 25;
  localparam int IIR_TAPS_DEFAULT = 5;
  localparam int SAMPLE_CNT_W     = 16;
  localparam int TAP_W            = 3;
  localparam int MAX_TAPS         = 1 << TAP_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // A new sample can start a sequence only from IDLE or the final DONE cycle.
  function automatic logic can_accept(input seq_state_t state);
    return (state == ST_IDLE) || (state == ST_DONE);
  endfunction

endpackage

// File: rtl/iir_seq_ctrl_if.sv
// Control bundle between the sample source / datapath and the IIR sequencer.
interface iir_seq_ctrl_if;
  import iir_pkg::*;

  logic                    enable;
  logic                    sample_valid;
  logic                    ovr_clr;
  logic [TAP_W-1:0]        tap_sel;
  logic                    acc_clr;
  logic                    acc_en;
  logic                    shift;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;
  logic [SAMPLE_CNT_W-1:0] sample_cnt;

  modport master (
    output enable, sample_valid, ovr_clr,
    input  tap_sel, acc_clr, acc_en, shift, out_valid, busy, overrun, sample_cnt
  );

  modport slave (
    input  enable, sample_valid, ovr_clr,
    output tap_sel, acc_clr, acc_en, shift, out_valid, busy, overrun, sample_cnt
  );

endinterface

// File: rtl/iir_seq_ctrl_tap_counter.sv
// Tap index counter for the MAC phase: cleared by load, stepped by enable,
// wrapping to zero after the terminal count TAPS-1.
module tap_counter
  import iir_pkg::*;
#(
  parameter int TAPS = IIR_TAPS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  output logic [TAP_W-1:0] count,
  output logic             tc
);

  logic [TAP_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tc ? '0 : count_q + 1'b1;
    end
  end

  assign tc    = (count_q == TAP_W'(TAPS - 1));
  assign count = count_q;

endmodule

// File: rtl/iir_seq_ctrl.sv
// Sequencer for a multiplexed direct-form IIR filter: per accepted sample it
// clears the accumulator, steps TAPS MAC terms, shifts history and flags output.
module iir_seq_ctrl
  import iir_pkg::*;
#(
  parameter int N    = IIR_N_DEFAULT,
  parameter int TAPS = IIR_TAPS_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  iir_seq_ctrl_if.slave ctrl
);

  localparam int WORD_W = 2 * N;

  // The datapath lives outside; only reject shapes the tap index cannot cover.
  if (WORD_W < 2 || TAPS < 1 || TAPS > MAX_TAPS) begin : g_bad_config
    $error("iir_seq_ctrl: inconsistent configuration N=%0d TAPS=%0d", N, TAPS);
  end

  seq_state_t              state_q;
  seq_state_t              state_d;
  logic                    take;
  logic                    lost;
  logic                    tap_load;
  logic                    tap_step;
  logic                    tap_tc;
  logic [TAP_W-1:0]        tap_count;
  logic                    overrun_q;
  logic [SAMPLE_CNT_W-1:0] sample_cnt_q;

  assign take     = ctrl.enable & ctrl.sample_valid;
  assign lost     = take & ~can_accept(state_q);
  assign tap_load = (state_q == ST_LOAD);
  assign tap_step = (state_q == ST_MAC);

  tap_counter #(
    .TAPS (TAPS)
  ) u_tap_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (tap_load),
    .enable (tap_step),
    .count  (tap_count),
    .tc     (tap_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE chains straight into LOAD so back-to-back samples lose no cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (take) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_MAC;
      ST_MAC:   if (tap_tc) state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_DONE;
      ST_DONE:  state_d = take ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl.tap_sel    = '0;
    ctrl.acc_clr    = 1'b0;
    ctrl.acc_en     = 1'b0;
    ctrl.shift      = 1'b0;
    ctrl.out_valid  = 1'b0;
    ctrl.busy       = (state_q != ST_IDLE);
    ctrl.overrun    = overrun_q;
    ctrl.sample_cnt = sample_cnt_q;
    case (state_q)
      ST_LOAD: ctrl.acc_clr = 1'b1;
      ST_MAC: begin
        ctrl.acc_en  = 1'b1;
        ctrl.tap_sel = tap_count;
      end
      ST_SHIFT: ctrl.shift     = 1'b1;
      ST_DONE:  ctrl.out_valid = 1'b1;
      default: ;
    endcase
  end

  // A lost sample wins over a simultaneous clear so no overrun goes unseen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (lost) begin
      overrun_q <= 1'b1;
    end else if (ctrl.ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt_q <= '0;
    end else if (state_q == ST_DONE) begin
      sample_cnt_q <= sample_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_iir_seq_ctrl.sv
// Self-checking bench for iir_seq_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a phase-offset reference model.
module tb_iir_seq_ctrl;
  import iir_pkg::*;

  localparam int TAPS = IIR_TAPS_DEFAULT;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: m_phase is cycles since the accepting edge (0 = idle).
  int          m_phase;
  bit          m_ovr;
  logic [15:0] m_cnt;

  iir_seq_ctrl_if bus ();

  iir_seq_ctrl #(
    .N    (IIR_N_DEFAULT),
    .TAPS (TAPS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] obs_outputs();
    return {bus.busy, bus.acc_clr, bus.acc_en, bus.shift, bus.out_valid,
            bus.overrun, bus.tap_sel, bus.sample_cnt};
  endfunction

  function automatic logic [24:0] model_outputs();
    logic busy_e, clr_e, en_e, shift_e, ov_e;
    logic [2:0] tap_e;
    busy_e  = (m_phase != 0);
    clr_e   = (m_phase == 1);
    en_e    = (m_phase >= 2) && (m_phase <= TAPS + 1);
    shift_e = (m_phase == TAPS + 2);
    ov_e    = (m_phase == TAPS + 3);
    tap_e   = en_e ? 3'(m_phase - 2) : 3'd0;
    return {busy_e, clr_e, en_e, shift_e, ov_e, m_ovr, tap_e, m_cnt};
  endfunction

  task automatic model_step(input bit en, input bit sv, input bit oc);
    bit req;
    bit in_seq;
    req    = en && sv;
    in_seq = (m_phase >= 1) && (m_phase < TAPS + 3);
    if (m_phase == TAPS + 3) m_cnt = m_cnt + 16'd1;
    if (req && in_seq) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
    if (req && !in_seq) m_phase = 1;
    else if (in_seq) m_phase = m_phase + 1;
    else m_phase = 0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ovr   = 1'b0;
    m_cnt   = 16'd0;
  endtask

  task automatic run_cycle(input bit en, input bit sv, input bit oc,
                           output logic [24:0] obs, output logic [24:0] exp);
    @(negedge clk);
    bus.enable       = en;
    bus.sample_valid = sv;
    bus.ovr_clr      = oc;
    @(posedge clk);
    model_step(en, sv, oc);
    #1;
    obs = obs_outputs();
    exp = model_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b0;
    bus.enable       = 1'b0;
    bus.sample_valid = 1'b0;
    bus.ovr_clr      = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [24:0] obs;
    reset            = 1'b0;
    bus.enable       = 1'b1;
    bus.sample_valid = 1'b1;
    bus.ovr_clr      = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      obs = obs_outputs();
      n_checks++;
      if (obs !== 25'h0) begin
        n_fails++;
        $display("[TB] FAIL reset_hold edge%0d: got %h expected %h", i, obs, 25'h0);
      end
    end
    @(negedge clk);
    bus.enable       = 1'b0;
    bus.sample_valid = 1'b0;
    reset            = 1'b1;
  endtask

  task automatic test_single();
    logic [24:0] obs, exp;
    int shift_at, out_at;
    shift_at = -1;
    out_at   = -1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b1, i == 0, 1'b0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL single cyc%0d: got %h expected %h", i + 1, obs, exp);
      end
      if (bus.shift === 1'b1) shift_at = i + 1;
      if (bus.out_valid === 1'b1) out_at = i + 1;
    end
    n_checks++;
    if (shift_at != TAPS + 2) begin
      n_fails++;
      $display("[TB] FAIL single_shift_cycle: got %0d expected %0d", shift_at, TAPS + 2);
    end
    n_checks++;
    if (out_at != TAPS + 3) begin
      n_fails++;
      $display("[TB] FAIL single_out_cycle: got %0d expected %0d", out_at, TAPS + 3);
    end
    n_checks++;
    if (bus.sample_cnt !== 16'd1) begin
      n_fails++;
      $display("[TB] FAIL single_count: got %0d expected 1", bus.sample_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] obs, exp;
    int shifts;
    shifts = 0;
    do_reset();
    for (int i = 0; i < 88; i++) begin
      run_cycle(1'b1, (i % (TAPS + 3) == 0) && (i < 10 * (TAPS + 3)), 1'b0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL b2b cyc%0d: got %h expected %h", i + 1, obs, exp);
      end
      if (bus.shift === 1'b1) shifts++;
    end
    n_checks++;
    if (shifts != 10) begin
      n_fails++;
      $display("[TB] FAIL b2b_shifts: got %0d expected 10", shifts);
    end
    n_checks++;
    if (bus.overrun !== 1'b0 || bus.sample_cnt !== 16'd10) begin
      n_fails++;
      $display("[TB] FAIL b2b_final: got ovr=%b cnt=%0d expected ovr=0 cnt=10",
               bus.overrun, bus.sample_cnt);
    end
  endtask

  task automatic test_overrun();
    logic [24:0] obs, exp;
    int shifts;
    shifts = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b1, (i == 0) || (i == 4), 1'b0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL ovr cyc%0d: got %h expected %h", i + 1, obs, exp);
      end
      if (bus.shift === 1'b1) shifts++;
    end
    n_checks++;
    if (shifts != 1 || bus.overrun !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL ovr_set: got shifts=%0d ovr=%b expected shifts=1 ovr=1",
               shifts, bus.overrun);
    end
    run_cycle(1'b1, 1'b0, 1'b1, obs, exp);
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL ovr_clear: got %b expected 0", bus.overrun);
    end
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b1, (i == 0) || (i == 2) || (i == 4), i == 4, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL ovr2 cyc%0d: got %h expected %h", i + 1, obs, exp);
      end
      if (i == 4) begin
        n_checks++;
        if (bus.overrun !== 1'b1) begin
          n_fails++;
          $display("[TB] FAIL ovr_set_priority: got %b expected 1", bus.overrun);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] obs, exp;
    int shifts;
    shifts = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, i == 0, 1'b0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL rstmid cyc%0d: got %h expected %h", i + 1, obs, exp);
      end
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    obs = obs_outputs();
    n_checks++;
    if (obs !== 25'h0) begin
      n_fails++;
      $display("[TB] FAIL rstmid_async: got %h expected %h", obs, 25'h0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.shift === 1'b1) shifts++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, obs, exp);
      if (bus.shift === 1'b1) shifts++;
    end
    n_checks++;
    if (shifts != 0 || bus.sample_cnt !== 16'd0 || bus.busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL rstmid_after: got shifts=%0d cnt=%0d busy=%b expected 0 0 0",
               shifts, bus.sample_cnt, bus.busy);
    end
  endtask

  task automatic test_enable();
    logic [24:0] obs, exp;
    int active, shift_at;
    active   = 0;
    shift_at = -1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_cycle(1'b0, (i % 3) == 0, 1'b0, obs, exp);
      if (bus.busy === 1'b1 || bus.overrun === 1'b1) active++;
    end
    n_checks++;
    if (active != 0) begin
      n_fails++;
      $display("[TB] FAIL enable_off_activity: got %0d active cycles expected 0", active);
    end
    for (int i = 0; i < 12; i++) begin
      run_cycle(i < 3, (i == 0) || (i == 5), 1'b0, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL enable_drop cyc%0d: got %h expected %h", i + 1, obs, exp);
      end
      if (bus.shift === 1'b1) shift_at = i + 1;
    end
    n_checks++;
    if (shift_at != 7 || bus.overrun !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL enable_drop_shift: got cyc=%0d ovr=%b expected cyc=7 ovr=0",
               shift_at, bus.overrun);
    end
  endtask

  task automatic test_random();
    logic [24:0] obs, exp;
    bit en, sv, oc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      sv = ($urandom_range(0, 4) == 0);
      oc = ($urandom_range(0, 15) == 0);
      run_cycle(en, sv, oc, obs, exp);
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("[TB] FAIL random cyc%0d: got %h expected %h", i + 1, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [24:0] obs, exp;
    do_reset();
    @(negedge clk);
    force dut.sample_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.sample_cnt_q;
    m_cnt = 16'hFFFE;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < TAPS + 5; i++) begin
        run_cycle(1'b1, i == 0, 1'b0, obs, exp);
        n_checks++;
        if (obs !== exp) begin
          n_fails++;
          $display("[TB] FAIL wrap s%0d cyc%0d: got %h expected %h", s, i + 1, obs, exp);
        end
      end
      n_checks++;
      if (bus.sample_cnt !== ((s == 0) ? 16'hFFFF : 16'h0000)) begin
        n_fails++;
        $display("[TB] FAIL wrap_count s%0d: got %h expected %h", s, bus.sample_cnt,
                 (s == 0) ? 16'hFFFF : 16'h0000);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_enable();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
